// File: rtl/frame_snapshot_controller.sv
// Single-frame snapshot sequencer between the camera frame buffer and the
// UART image sender, plus read-port arbitration between the sender and an
// auxiliary reader.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | camera writes enabled, waiting for snap_req or auto_mode
// WAIT_FRAME | camera writes enabled, waiting for the current frame_end
// FREEZE     | writes frozen, guard period so in-flight writes drain
// START      | one-cycle sender_start pulse
// SEND       | sender owns the read port, watching for done or timeout
// RELEASE    | writes re-enabled, choose IDLE or SETTLE
// SETTLE     | auto mode: let SETTLE_FRAMES frames pass before re-arming
module frame_snapshot_controller #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 12,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SETTLE_FRAMES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap_req,
  input  logic              auto_mode,
  input  logic              frame_end,
  output logic              cam_write_en,
  output logic              sender_start,
  input  logic              sender_done,
  input  logic [ADDR_W-1:0] sender_addr,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_grant,
  output logic              aux_rdata_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        snap_count
);

  localparam int GUARD_W   = $clog2(GUARD_CYCLES + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SETTLE_W  = $clog2(SETTLE_FRAMES + 1);

  localparam logic [GUARD_W-1:0]   GUARD_LAST   = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_FRAMES - 1);

  // Counters compare against value-1, so every count must be at least one.
  if (DATA_W < 1 || GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || SETTLE_FRAMES < 1) begin : g_param_check
    $error("frame_snapshot_controller: DATA_W and all cycle/frame counts must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    FREEZE,
    START,
    SEND,
    RELEASE,
    SETTLE
  } state_t;

  state_t               state_q, state_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [TIMEOUT_W-1:0] send_cnt_q, send_cnt_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]           snap_count_q, snap_count_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 aux_rdata_valid_q, aux_rdata_valid_d;
  logic                 frozen;

  // State, counters and sticky flags; counters fall back to zero whenever
  // their owning state is not active, so each starts at zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      guard_cnt_q       <= '0;
      send_cnt_q        <= '0;
      settle_cnt_q      <= '0;
      snap_count_q      <= '0;
      timeout_err_q     <= 1'b0;
      aux_rdata_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      guard_cnt_q       <= guard_cnt_d;
      send_cnt_q        <= send_cnt_d;
      settle_cnt_q      <= settle_cnt_d;
      snap_count_q      <= snap_count_d;
      timeout_err_q     <= timeout_err_d;
      aux_rdata_valid_q <= aux_rdata_valid_d;
    end
  end

  // Next-state, counter and flag updates.
  always_comb begin
    state_d       = state_q;
    guard_cnt_d   = '0;
    send_cnt_d    = '0;
    settle_cnt_d  = '0;
    snap_count_d  = snap_count_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          timeout_err_d = 1'b0;
          state_d       = WAIT_FRAME;
        end else if (auto_mode) begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_end) state_d = FREEZE;
      end
      FREEZE: begin
        if (guard_cnt_q == GUARD_LAST) state_d = START;
        else guard_cnt_d = guard_cnt_q + 1'b1;
      end
      START: state_d = SEND;
      SEND: begin
        // A done arriving on the timeout cycle still counts as a success.
        if (sender_done) begin
          snap_count_d = snap_count_q + 8'd1;
          state_d      = RELEASE;
        end else if (send_cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end else begin
          send_cnt_d = send_cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = auto_mode ? SETTLE : IDLE;
      SETTLE: begin
        settle_cnt_d = settle_cnt_q;
        if (!auto_mode) begin
          state_d = IDLE;
        end else if (frame_end) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = WAIT_FRAME;
          else settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the registered state so reset takes
  // effect on them without waiting for a clock.
  always_comb begin
    frozen            = (state_q == FREEZE) || (state_q == START) || (state_q == SEND);
    cam_write_en      = !frozen;
    sender_start      = (state_q == START);
    busy              = (state_q != IDLE);
    aux_grant         = aux_req && !frozen;
    mem_addr          = frozen ? sender_addr : aux_addr;
    aux_rdata_valid_d = aux_grant;
    aux_rdata_valid   = aux_rdata_valid_q;
    timeout_err       = timeout_err_q;
    snap_count        = snap_count_q;
  end

endmodule

// File: tb/tb_frame_snapshot_controller.sv
// Bench for frame_snapshot_controller: a timeline model of when the buffer is
// frozen and when the block is busy, plus queues of expected start pulses and
// release events consumed by an independent monitor.
module tb_frame_snapshot_controller;

  localparam int ADDR_W  = 17;
  localparam int GUARD   = 4;
  localparam int TIMEOUT = 100;
  localparam int SETTLE  = 2;
  localparam int MAXC    = 8192;

  logic              clk, rst_n;
  logic              snap_req, auto_mode, frame_end;
  logic              cam_write_en, sender_start, sender_done;
  logic [ADDR_W-1:0] sender_addr, aux_addr, mem_addr;
  logic              aux_req, aux_grant, aux_rdata_valid;
  logic              busy, timeout_err;
  logic [7:0]        snap_count;

  frame_snapshot_controller #(
    .ADDR_W(ADDR_W), .DATA_W(12), .GUARD_CYCLES(GUARD),
    .TIMEOUT_CYCLES(TIMEOUT), .SETTLE_FRAMES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .auto_mode(auto_mode),
    .frame_end(frame_end), .cam_write_en(cam_write_en), .sender_start(sender_start),
    .sender_done(sender_done), .sender_addr(sender_addr), .aux_req(aux_req),
    .aux_addr(aux_addr), .aux_grant(aux_grant), .aux_rdata_valid(aux_rdata_valid),
    .mem_addr(mem_addr), .busy(busy), .timeout_err(timeout_err), .snap_count(snap_count)
  );

  typedef struct {
    int cyc;
    int cnt;
    bit terr;
  } rel_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  bit   aux_hold = 0;
  bit   fixed_addr = 0;
  bit   exp_frozen [MAXC];
  bit   exp_busy [MAXC];
  int   start_q [$];
  rel_t rel_q [$];
  int   m_count = 0;
  bit   m_terr = 0;
  bit   prev_eg = 0;
  bit   prev_cwe = 1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20 * MAXC * 10);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void set_frozen(input int from, input int to, input bit v);
    for (int i = from; i <= to && i < MAXC; i++) exp_frozen[i] = v;
  endfunction

  function automatic void set_busy(input int from, input int to, input bit v);
    for (int i = from; i <= to && i < MAXC; i++) exp_busy[i] = v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read-port side inputs change every cycle.
  always @(posedge clk) begin
    #1;
    aux_req     = aux_hold ? 1'b1 : 1'($urandom);
    sender_addr = fixed_addr ? 17'h12C00 : ADDR_W'($urandom);
    aux_addr    = fixed_addr ? 17'h00005 : ADDR_W'($urandom);
  end

  // Monitor: per-cycle level checks against the timeline, event checks
  // against the queues.
  always @(negedge clk) begin
    bit fz, eg;
    fz = (cyc < MAXC) ? exp_frozen[cyc] : 1'b0;
    eg = aux_req && !fz;
    if (chk_en && rst_n) begin
      chk("aux_grant", aux_grant, eg);
      chk("aux_rdata_valid", aux_rdata_valid, prev_eg);
      chk("mem_addr", mem_addr, fz ? sender_addr : aux_addr);
      chk("cam_write_en", cam_write_en, !fz);
      chk("busy", busy, (cyc < MAXC) ? exp_busy[cyc] : 1'b0);
      if (sender_start) begin
        if (start_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_start at cycle %0d: got a pulse, expected none", cyc);
        end else begin
          chk("start_cycle", cyc, start_q.pop_front());
        end
      end
      if (start_q.size() > 0 && start_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_start: got none, expected a pulse at cycle %0d", start_q.pop_front());
      end
      if (!prev_cwe && cam_write_en) begin
        if (rel_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_release at cycle %0d: got a release, expected none", cyc);
        end else begin
          rel_t e;
          e = rel_q.pop_front();
          chk("release_cycle", cyc, e.cyc);
          chk("snap_count", snap_count, e.cnt);
          chk("timeout_err", timeout_err, e.terr);
        end
      end
      if (rel_q.size() > 0 && rel_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_release: got none, expected release at cycle %0d", rel_q.pop_front().cyc);
      end
    end
    prev_eg  = rst_n ? eg : 1'b0;
    prev_cwe = cam_write_en;
  end

  // One snapshot: optional snap_req, settle_n+1 frame_end pulses, then done
  // after done_dly SEND cycles or a timeout. Returns one cycle after RELEASE.
  task automatic run_snap(input int settle_n, input bit use_req, input bit to_case,
                          input int done_dly, input bit extra_req, input bit stray_fe,
                          input bit auto_m);
    int q, k, s, d, r;
    if (use_req) begin
      q = cyc;
      snap_req = 1;
      set_busy(q + 1, MAXC - 1, 1);
      step();
      snap_req = 0;
      m_terr = 0;
      chk("timeout_err_cleared", timeout_err, 0);
    end
    k = cyc;
    for (int i = 0; i <= settle_n; i++) begin
      repeat ($urandom_range(1, 8)) step();
      k = cyc;
      frame_end = 1;
      step();
      frame_end = 0;
    end
    s = k + 2 + GUARD;
    if (to_case) begin
      r = s + TIMEOUT;
      d = r;
    end else begin
      d = s + done_dly;
      r = d + 1;
    end
    start_q.push_back(k + 1 + GUARD);
    set_frozen(k + 1, r - 1, 1);
    if (to_case) m_terr = 1;
    else m_count = (m_count + 1) % 256;
    rel_q.push_back('{r, m_count, m_terr});
    if (!auto_m) set_busy(r + 1, MAXC - 1, 0);
    while (cyc <= r) begin
      sender_done = (cyc == d);
      snap_req    = extra_req && (cyc == s);
      frame_end   = stray_fe && (cyc == s + 1 || cyc == r);
      step();
    end
    sender_done = 0;
    snap_req    = 0;
    frame_end   = 0;
  endtask

  initial begin
    int a, x, k, s;
    rst_n = 0; snap_req = 0; auto_mode = 0; frame_end = 0; sender_done = 0;
    aux_req = 0; sender_addr = '0; aux_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cam_write_en", cam_write_en, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sender_start", sender_start, 0);
    chk("rst_aux_rdata_valid", aux_rdata_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_snap_count", snap_count, 0);
    rst_n = 1;
    step();
    step();
    chk_en = 1;

    // Fixed addresses through one full snapshot.
    fixed_addr = 1;
    run_snap(0, 1, 0, 20, 0, 0, 0);
    fixed_addr = 0;
    // Timeout with a late done and stray frame_end pulses, then a clearing request.
    run_snap(0, 1, 1, 0, 0, 1, 0);
    run_snap(0, 1, 0, 5, 0, 0, 0);
    // Done on the timeout cycle, with an ignored request during SEND.
    run_snap(0, 1, 0, TIMEOUT - 1, 1, 0, 0);
    run_snap(0, 1, 0, 0, 1, 1, 0);
    for (int n = 0; n < 6; n++)
      run_snap(0, 1, ($urandom_range(0, 3) == 0), $urandom_range(0, TIMEOUT - 1),
               1'($urandom), 1'($urandom), 0);

    // Auto mode: three snapshots with aux_req held.
    aux_hold = 1;
    a = cyc;
    auto_mode = 1;
    set_busy(a + 1, MAXC - 1, 1);
    step();
    run_snap(0, 0, 0, $urandom_range(0, TIMEOUT - 1), 0, 1, 1);
    run_snap(SETTLE, 0, 0, $urandom_range(0, TIMEOUT - 1), 1, 1, 1);
    run_snap(SETTLE, 0, 0, $urandom_range(0, TIMEOUT - 1), 0, 1, 1);
    step();
    step();
    x = cyc;
    set_busy(x + 1, MAXC - 1, 0);
    auto_mode = 0;
    step();
    aux_hold = 0;
    step();

    // Reset asserted between edges while in SEND.
    snap_req = 1;
    set_busy(cyc + 1, MAXC - 1, 1);
    step();
    snap_req = 0;
    m_terr = 0;
    step();
    step();
    k = cyc;
    frame_end = 1;
    step();
    frame_end = 0;
    s = k + 2 + GUARD;
    start_q.push_back(k + 1 + GUARD);
    set_frozen(k + 1, MAXC - 1, 1);
    while (cyc < s + 5) step();
    chk_en = 0;
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_cam_write_en", cam_write_en, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_snap_count", snap_count, 0);
    chk("async_rst_sender_start", sender_start, 0);
    start_q.delete();
    rel_q.delete();
    m_count = 0;
    m_terr = 0;
    set_frozen(cyc, MAXC - 1, 0);
    set_busy(cyc, MAXC - 1, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    step();
    chk_en = 1;
    step();
    chk("post_rst_busy", busy, 0);
    run_snap(0, 1, 0, $urandom_range(0, TIMEOUT - 1), 0, 0, 0);

    repeat (5) step();
    chk("start_queue_drained", start_q.size(), 0);
    chk("release_queue_drained", rel_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
